// File: rtl/seg7_mux_capture.sv
// seg7_mux_capture: recovers per-digit hex/blank/error from a multiplexed active-low 7-seg bus; define SEG7_CAP_DP_EN to also capture the decimal point
module seg7_mux_capture #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
`ifdef SEG7_CAP_DP_EN
   input  logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   dp_out,
`endif
   output logic [4*NUM_DIGITS-1:0] hex_out,
   output logic [NUM_DIGITS-1:0]   blank_out,
   output logic [NUM_DIGITS-1:0]   err_out,
   output logic                    frame_valid,
   output logic                    frame_strobe
);
   localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
`ifdef SEG7_CAP_DP_EN
   localparam int SW = 8;
   wire [SW-1:0] samp_in = {dp_n, seg_n};
`else
   localparam int SW = 7;
   wire [SW-1:0] samp_in = seg_n;
`endif
   localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [NUM_DIGITS-1:0] an_s1, an_s2, sel, seen, seen_nxt;
   logic [SW-1:0]         samp_s1, samp_s2, prev_samp;
   logic [DW-1:0]         dig, prev_dig;
   logic [7:0]            cnt, cnt_nxt;
   logic [6:0]            pat;
   logic [3:0]            val;
   logic                  one, same, hit, full, commit_q;

   // two-flop synchronisers on the display pins
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         an_s1   <= '0;
         an_s2   <= '0;
         samp_s1 <= '0;
         samp_s2 <= '0;
      end else begin
         an_s1   <= an_n;
         an_s2   <= an_s1;
         samp_s1 <= samp_in;
         samp_s2 <= samp_s1;
      end

   // select decode, stability counting and decode of the committed sample
   always_comb begin
      sel = ~an_s2;
      one = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
      dig = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (sel[i]) dig = DW'(i);
      same     = (cnt != 8'd0) && (dig == prev_dig) && (samp_s2 == prev_samp);
      cnt_nxt  = !one ? 8'd0 : !same ? 8'd1 : (cnt == 8'hFF) ? cnt : cnt + 8'd1;
      pat      = ~prev_samp[6:0];
      hit      = 1'b0;
      val      = 4'd0;
      for (int i = 0; i < 16; i++)
         if (pat == HEX7[i]) begin
            hit = 1'b1;
            val = 4'(i);
         end
      seen_nxt = seen | (NUM_DIGITS'(1) << prev_dig);
      full     = seen_nxt == {NUM_DIGITS{1'b1}};
   end

   // dwell tracking; commit fires once, on the cycle the count reaches the threshold
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         cnt       <= '0;
         prev_dig  <= '0;
         prev_samp <= '0;
         commit_q  <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         prev_dig  <= dig;
         prev_samp <= samp_s2;
         commit_q  <= (cnt_nxt == 8'(STABLE_CYCLES)) && (cnt != 8'(STABLE_CYCLES));
      end

   // registered per-digit view and frame tracking, updated the cycle after commit
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         hex_out      <= '0;
         blank_out    <= '1;
         err_out      <= '0;
         seen         <= '0;
         frame_valid  <= 1'b0;
         frame_strobe <= 1'b0;
      end else begin
         frame_strobe <= commit_q && full;
         if (commit_q) begin
            seen                <= full ? '0 : seen_nxt;
            frame_valid         <= frame_valid | full;
            blank_out[prev_dig] <= pat == 7'h00;
            err_out[prev_dig]   <= (pat != 7'h00) && !hit;
            if (hit) hex_out[4*prev_dig +: 4] <= val;
         end
      end

`ifdef SEG7_CAP_DP_EN
   // decimal point captured on every commit, blank and error included
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) dp_out <= '0;
      else if (commit_q) dp_out[prev_dig] <= ~prev_samp[7];
`endif
endmodule

// File: tb/tb_seg7_mux_capture.sv
// tb_seg7_mux_capture: directed vector table plus hand sequences for latency, dwell and reset
module tb_seg7_mux_capture;
   logic        clk = 1'b0, resetn = 1'b0;
   logic [6:0]  seg_n = 7'h7F;
   logic [3:0]  an_n = 4'hF;
   logic [15:0] hex_out;
   logic [3:0]  blank_out, err_out;
   logic        frame_valid, frame_strobe;
`ifdef SEG7_CAP_DP_EN
   logic        dp_n = 1'b1;
   logic [3:0]  dp_out;
`endif
   int total = 0, bad = 0, strobes = 0;

   seg7_mux_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
`ifdef SEG7_CAP_DP_EN
      .dp_n(dp_n), .dp_out(dp_out),
`endif
      .clk(clk), .resetn(resetn), .seg_n(seg_n), .an_n(an_n), .hex_out(hex_out),
      .blank_out(blank_out), .err_out(err_out), .frame_valid(frame_valid),
      .frame_strobe(frame_strobe));

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_strobe) strobes++;

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      int          cyc;
      bit          rst;
      logic [15:0] hex;
      logic [3:0]  blank;
      logic [3:0]  err;
      logic        valid;
      int          nstb;
   } vec_t;
   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [15:0] h, input logic [3:0] b,
                          input logic [3:0] e, input logic v, input int s);
      chk({tag, " hex"}, 32'(hex_out), 32'(h));
      chk({tag, " blank"}, 32'(blank_out), 32'(b));
      chk({tag, " err"}, 32'(err_out), 32'(e));
      chk({tag, " valid"}, 32'(frame_valid), 32'(v));
      chk({tag, " strobes"}, 32'(strobes), 32'(s));
   endtask

   initial begin
      tbl[0]  = '{4'b1110, ~7'h06, 12, 0, 16'h0001, 4'b1110, 4'b0000, 1'b0, 0};
      tbl[1]  = '{4'b1101, ~7'h77, 12, 0, 16'h00A1, 4'b1100, 4'b0000, 1'b0, 0};
      tbl[2]  = '{4'b1011, ~7'h71, 12, 0, 16'h0FA1, 4'b1000, 4'b0000, 1'b0, 0};
      tbl[3]  = '{4'b0111, ~7'h7F, 12, 0, 16'h8FA1, 4'b0000, 4'b0000, 1'b1, 1};
      tbl[4]  = '{4'b1011,  7'h7F, 12, 0, 16'h8FA1, 4'b0100, 4'b0000, 1'b1, 1};
      tbl[5]  = '{4'b1101, ~7'h40, 12, 0, 16'h8FA1, 4'b0100, 4'b0010, 1'b1, 1};
      tbl[6]  = '{4'b0111, ~7'h3F, 12, 0, 16'h0FA1, 4'b0100, 4'b0010, 1'b1, 1};
      tbl[7]  = '{4'b1110, ~7'h5B,  7, 0, 16'h0FA1, 4'b0100, 4'b0010, 1'b1, 1};
      tbl[8]  = '{4'b1111, ~7'h5B, 20, 0, 16'h0FA1, 4'b0100, 4'b0010, 1'b1, 1};
      tbl[9]  = '{4'b1100, ~7'h5B, 20, 0, 16'h0FA1, 4'b0100, 4'b0010, 1'b1, 1};
      tbl[10] = '{4'b1110, ~7'h5B, 12, 0, 16'h0FA2, 4'b0100, 4'b0010, 1'b1, 2};
      tbl[11] = '{4'b1101, ~7'h06,  5, 1, 16'h0000, 4'b1111, 4'b0000, 1'b0, 2};
      tbl[12] = '{4'b1101, ~7'h06, 12, 0, 16'h0010, 4'b1101, 4'b0000, 1'b0, 2};
      tbl[13] = '{4'b1110, ~7'h3F, 12, 0, 16'h0010, 4'b1100, 4'b0000, 1'b0, 2};
      tbl[14] = '{4'b1011, ~7'h66, 12, 0, 16'h0410, 4'b1000, 4'b0000, 1'b0, 2};
      tbl[15] = '{4'b0111, ~7'h6D, 12, 0, 16'h5410, 4'b0000, 4'b0000, 1'b1, 3};

      step(3);
      chk_all("reset", 16'h0000, 4'b1111, 4'b0000, 1'b0, 0);
      chk("reset strobe", 32'(frame_strobe), 32'd0);
`ifdef SEG7_CAP_DP_EN
      chk("reset dp", 32'(dp_out), 32'd0);
`endif
      resetn = 1'b1;
      an_n   = 4'b1110;
      seg_n  = ~7'h5B;
      step(10);
      chk("latency early hex", 32'(hex_out), 32'h0);
      chk("latency early blank", 32'(blank_out), 32'hF);
      step(1);
      chk_all("latency", 16'h0002, 4'b1110, 4'b0000, 1'b0, 0);
      step(9);
      chk_all("hold", 16'h0002, 4'b1110, 4'b0000, 1'b0, 0);

      for (int i = 0; i < 16; i++) begin
         an_n  = tbl[i].an;
         seg_n = tbl[i].seg;
         step(tbl[i].cyc);
         if (tbl[i].rst) begin
            resetn = 1'b0;
            step(1);
            resetn = 1'b1;
         end
         chk_all($sformatf("vec%0d", i), tbl[i].hex, tbl[i].blank, tbl[i].err, tbl[i].valid, tbl[i].nstb);
      end

`ifdef SEG7_CAP_DP_EN
      an_n  = 4'b1110;
      seg_n = ~7'h4F;
      dp_n  = 1'b0;
      step(12);
      chk("dp hex", 32'(hex_out[3:0]), 32'h3);
      chk("dp out", 32'(dp_out[0]), 32'h1);
      seg_n = ~7'h06;
      for (int k = 0; k < 8; k++) begin
         dp_n = ~dp_n;
         step(4);
      end
      chk("dp toggle hex", 32'(hex_out[3:0]), 32'h3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seg7_mux_capture.md
Name: seg7_mux_capture

Overview:
- Reads back a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects) and recovers each digit's hex value.
- Is the decode end of the hex-to-7-segment encode path: sits on the display pins for loopback self-test and board bring-up.
- Presents a registered per-digit hex/blank/error view and a frame-complete strobe.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 8, consecutive identical samples required before a digit is committed (2..255).

Ports:
- clk  input  1  system clock
- resetn  input  1  reset, asynchronous, active-low
- seg_n  input  7  segment lines, active-low, bit0=a ... bit6=g
- an_n  input  NUM_DIGITS  digit selects, active-low, bit0 = digit 0
- hex_out  output  4*NUM_DIGITS  decoded value, digit i at [4i+3:4i]
- blank_out  output  NUM_DIGITS  digit i last committed as all-segments-off
- err_out  output  NUM_DIGITS  digit i last committed as a non-hex pattern
- frame_valid  output  1  every digit committed at least once since reset
- frame_strobe  output  1  one-cycle pulse when the current frame completes

Behaviour:
- Reset values: hex_out=0, blank_out=all 1, err_out=0, frame_valid=0, frame_strobe=0, all internal state cleared.
- Reset is asynchronous assert; deassert mid-scan restarts capture from the empty state.
- Input sync: seg_n and an_n each pass through 2-FF synchronisers. All decisions use the synchronised values.
- Select decode:
  - Exactly one an_n bit low: active digit = that bit.
  - Zero or multiple bits low: idle/ghost. Stability counter clears to 0, no commit.
- Stability counter: 8 bits, saturating.
  - Same digit and same seg_n as the previous sample: increment.
  - Otherwise: load 1.
- Commit: on the cycle the counter reaches STABLE_CYCLES (equality, not >=), digit d is committed. At most one commit per dwell, because the counter saturates past the threshold without re-commit.
- Commit decode, pattern = ~seg_n in gfedcba order:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
  - Match: hex_out[d]=value, blank_out[d]=0, err_out[d]=0.
  - Pattern 00 (seg_n=7F): blank_out[d]=1, err_out[d]=0, hex_out[d] unchanged.
  - Any other pattern: err_out[d]=1, blank_out[d]=0, hex_out[d] unchanged.
- Outputs update one cycle after the commit cycle (registered). Latency from pins to hex_out = 2 sync + STABLE_CYCLES + 1 cycles.
- Frame tracking:
  - seen mask of NUM_DIGITS bits; a commit sets seen[d].
  - When the mask becomes all ones: frame_strobe pulses for exactly one cycle, frame_valid sets and stays 1 until reset, and the mask clears in the same cycle.
  - A commit in the mask-clear cycle is counted toward the next frame.
- Re-committing a digit already in seen: outputs update, mask unchanged.
- Digit change mid-dwell (anode moves before threshold): counter loads 1, no commit for the abandoned digit.

Optional Feature:
- Macro: SEG7_CAP_DP_EN.
- Defined:
  - Adds input dp_n (1 bit, active-low, synchronised like seg_n) and output dp_out (NUM_DIGITS).
  - dp_n participates in the stability comparison.
  - dp_out[d] <= ~dp_n at commit, including on blank/error commits.
  - dp_out resets to 0.
- Undefined: no dp_n/dp_out ports; decimal point ignored.

Test Plan:
- Reset then hold an_n=1110, seg_n=~7'h5B for 20 cycles -> hex_out[3:0]=2 after 2+8+1 cycles, blank_out[0]=0, err_out[0]=0, frame_strobe stays 0.
- Scan digits 0..3 with 1,A,F,8 (seg_n=~06,~77,~71,~7F), 12 cycles each -> hex_out=16'h8FA1, single frame_strobe pulse after digit 3 commits, frame_valid=1 thereafter.
- Digit 2 driven seg_n=7F -> blank_out[2]=1, hex_out[11:8] keeps prior value; digit 1 driven ~7'h40 (g only) -> err_out[1]=1.
- Dwell of 7 cycles (STABLE_CYCLES-1) then an_n=1111 -> no commit, outputs unchanged; an_n=1100 held 20 cycles -> no commit.
- Assert resetn low for 1 cycle mid-scan after a full frame -> outputs return to reset values; frame_valid=0 until four new commits.
- With SEG7_CAP_DP_EN: digit 0 showing 3 with dp_n=0 -> hex_out[3:0]=3, dp_out[0]=1; toggling dp_n every 4 cycles -> no commit.
